// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states,
// instruction classes, opcode / ALU / writeback-mux codes.
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } cu_state_e;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_NOP   = 2'd3
  } cu_class_e;

  // Opcodes are zero-extended to OPCODE_W at the point of use.
  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;
  localparam int OP_NOP   = 4;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;

  localparam int MUX_ALU     = 0;
  localparam int MUX_ALU_SUB = 1;
  localparam int MUX_MEM     = 2;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, memory acknowledge and datapath control lines.
// slave = control unit side, master = instruction source / datapath side.
interface cu_if #(
  parameter int OPCODE_W  = 4,
  parameter int ALU_OP_W  = 2,
  parameter int MUX_SEL_W = 2
);
  logic                 instr_valid;
  logic [OPCODE_W-1:0]  opcode;
  logic                 instr_ready;
  logic                 mem_ack;
  logic                 reg_write_enable;
  logic [ALU_OP_W-1:0]  alu_op;
  logic                 mem_read;
  logic                 mem_write;
  logic [MUX_SEL_W-1:0] mux_sel;
  logic                 illegal_op;
  logic                 mem_fault;

  modport slave (
    input  instr_valid, opcode, mem_ack,
    output instr_ready, reg_write_enable, alu_op, mem_read, mem_write,
           mux_sel, illegal_op, mem_fault
  );

  modport master (
    output instr_valid, opcode, mem_ack,
    input  instr_ready, reg_write_enable, alu_op, mem_read, mem_write,
           mux_sel, illegal_op, mem_fault
  );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational opcode lookup: instruction class, ALU operation, writeback
// source and legality.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int ALU_OP_W  = 2,
  parameter int MUX_SEL_W = 2
) (
  input  logic [OPCODE_W-1:0]  i_opcode,
  output cu_class_e            o_class,
  output logic [ALU_OP_W-1:0]  o_alu_op,
  output logic [MUX_SEL_W-1:0] o_mux_sel,
  output logic                 o_legal
);

  always_comb begin
    o_class   = CLS_NOP;
    o_alu_op  = ALU_OP_W'(ALU_ADD);
    o_mux_sel = MUX_SEL_W'(MUX_ALU);
    o_legal   = 1'b0;
    case (i_opcode)
      OPCODE_W'(OP_ADD): begin
        o_class = CLS_ALU;
        o_legal = 1'b1;
      end
      OPCODE_W'(OP_SUB): begin
        o_class   = CLS_ALU;
        o_alu_op  = ALU_OP_W'(ALU_SUB);
        o_mux_sel = MUX_SEL_W'(MUX_ALU_SUB);
        o_legal   = 1'b1;
      end
      // Memory ops use the ALU adder for address generation.
      OPCODE_W'(OP_LOAD): begin
        o_class   = CLS_LOAD;
        o_mux_sel = MUX_SEL_W'(MUX_MEM);
        o_legal   = 1'b1;
      end
      OPCODE_W'(OP_STORE): begin
        o_class = CLS_STORE;
        o_legal = 1'b1;
      end
      OPCODE_W'(OP_NOP): begin
        o_class = CLS_NOP;
        o_legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: IDLE -> EXEC -> (MEM) -> (WB) sequencing with a
// valid/ready instruction handshake and a bounded wait on the memory ack.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 2,
  parameter int MUX_SEL_W   = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  cu_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  cu_state_e            r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [OPCODE_W-1:0]  r_opcode, w_opcode_next;
  logic                 r_fault, w_fault_next;

  cu_class_e            w_class;
  logic [ALU_OP_W-1:0]  w_alu_op;
  logic [MUX_SEL_W-1:0] w_mux_sel;
  logic                 w_legal;
  logic                 w_ready;

  cu_decode #(
    .OPCODE_W  (OPCODE_W),
    .ALU_OP_W  (ALU_OP_W),
    .MUX_SEL_W (MUX_SEL_W)
  ) u_decode (
    .i_opcode  (r_opcode),
    .o_class   (w_class),
    .o_alu_op  (w_alu_op),
    .o_mux_sel (w_mux_sel),
    .o_legal   (w_legal)
  );

  // Ready is the only output that looks past the state: it stays low while reset is held.
  assign w_ready         = rst_n && (r_state == IDLE);
  assign bus.instr_ready = w_ready;
  assign bus.mem_fault   = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_opcode <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_opcode <= w_opcode_next;
      r_fault  <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_cnt_next           = r_cnt;
    w_opcode_next        = r_opcode;
    w_fault_next         = 1'b0;
    bus.reg_write_enable = 1'b0;
    bus.alu_op           = '0;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.mux_sel          = '0;
    bus.illegal_op       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.instr_valid && w_ready) begin
          w_opcode_next = bus.opcode;
          w_state_next  = EXEC;
        end
      end
      EXEC: begin
        w_cnt_next = '0;
        if (!w_legal) begin
          bus.illegal_op = 1'b1;
          w_state_next   = IDLE;
        end else begin
          bus.alu_op = w_alu_op;
          case (w_class)
            CLS_ALU:             w_state_next = WB;
            CLS_LOAD, CLS_STORE: w_state_next = MEM;
            default:             w_state_next = IDLE;
          endcase
        end
      end
      MEM: begin
        bus.mem_read  = (w_class == CLS_LOAD);
        bus.mem_write = (w_class == CLS_STORE);
        // An ack in the last counted cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          w_state_next = (w_class == CLS_LOAD) ? WB : IDLE;
        end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          w_state_next = IDLE;
          w_fault_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WB: begin
        bus.reg_write_enable = 1'b1;
        bus.mux_sel          = w_mux_sel;
        w_state_next         = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: checks the full output vector
// each cycle against hand-derived expectations.
module tb_multicycle_control_unit;
  localparam int OPCODE_W    = 4;
  localparam int ALU_OP_W    = 2;
  localparam int MUX_SEL_W   = 2;
  localparam int MEM_TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cu_if #(.OPCODE_W(OPCODE_W), .ALU_OP_W(ALU_OP_W), .MUX_SEL_W(MUX_SEL_W)) bus ();

  multicycle_control_unit #(
    .OPCODE_W    (OPCODE_W),
    .ALU_OP_W    (ALU_OP_W),
    .MUX_SEL_W   (MUX_SEL_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, we, alu_op[1:0], rd, wr, mux[1:0], illegal, fault}
  function automatic logic [9:0] ev(bit rdy, bit we, int alu, bit rd, bit wr,
                                    int mux, bit ill, bit flt);
    logic [1:0] a;
    logic [1:0] m;
    a = alu[1:0];
    m = mux[1:0];
    return {rdy, we, a, rd, wr, m, ill, flt};
  endfunction

  task automatic chk(input string tag, input logic [9:0] expv);
    logic [9:0] o;
    o = {bus.instr_ready, bus.reg_write_enable, bus.alu_op, bus.mem_read,
         bus.mem_write, bus.mux_sel, bus.illegal_op, bus.mem_fault};
    total++;
    assert (o === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, expv);
    end
    $display("check %-14s observed=%b expected=%b", tag, o, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
  endtask

  task automatic drop();
    bus.instr_valid = 1'b0;
    bus.opcode      = 4'hF;
  endtask

  logic [9:0] V_IDLE;
  logic [9:0] V_ZERO;

  initial begin
    total = 0;
    bad   = 0;
    V_IDLE = ev(1, 0, 0, 0, 0, 0, 0, 0);
    V_ZERO = ev(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.mem_ack     = 1'b0;

    tick(); tick();
    chk("rst_held", V_ZERO);
    rst_n = 1'b1;
    #1;
    chk("rst_release", V_IDLE);

    // ADD
    present(4'd0); chk("add_t0", V_IDLE);
    tick(); drop(); chk("add_t1_exec", ev(0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("add_t2_wb", ev(0, 1, 0, 0, 0, 0, 0, 0));
    tick(); chk("add_t3_idle", V_IDLE);

    // SUB then LOAD back-to-back, ack on 3rd MEM cycle
    present(4'd1);
    tick(); drop(); chk("sub_exec", ev(0, 0, 1, 0, 0, 0, 0, 0));
    tick(); chk("sub_wb", ev(0, 1, 0, 0, 0, 1, 0, 0));
    tick(); chk("sub_idle", V_IDLE); present(4'd2);
    tick(); drop(); chk("ld_exec", ev(0, 0, 0, 0, 0, 0, 0, 0));
    tick(); chk("ld_mem1", ev(0, 0, 0, 1, 0, 0, 0, 0));
    tick(); chk("ld_mem2", ev(0, 0, 0, 1, 0, 0, 0, 0));
    tick(); chk("ld_mem3", ev(0, 0, 0, 1, 0, 0, 0, 0)); bus.mem_ack = 1'b1;
    tick(); bus.mem_ack = 1'b0; chk("ld_wb", ev(0, 1, 0, 0, 0, 2, 0, 0));
    tick(); chk("ld_idle", V_IDLE);

    // STORE with no ack: timeout after MEM_TIMEOUT cycles
    present(4'd3);
    tick(); drop(); chk("st_exec", ev(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      tick(); chk($sformatf("st_mem%0d", i + 1), ev(0, 0, 0, 0, 1, 0, 0, 0));
    end
    tick(); chk("st_fault", ev(1, 0, 0, 0, 0, 0, 0, 1));
    tick(); chk("st_fault_gone", V_IDLE);

    // Illegal opcode
    present(4'hF);
    tick(); drop(); chk("ill_t1", ev(0, 0, 0, 0, 0, 0, 1, 0));
    tick(); chk("ill_t2_idle", V_IDLE);

    // NOP
    present(4'd4);
    tick(); drop(); chk("nop_t1", V_ZERO);
    tick(); chk("nop_t2_idle", V_IDLE);

    // STORE with immediate ack
    present(4'd3);
    tick(); drop(); chk("st2_exec", V_ZERO);
    tick(); chk("st2_mem1", ev(0, 0, 0, 0, 1, 0, 0, 0)); bus.mem_ack = 1'b1;
    tick(); bus.mem_ack = 1'b0; chk("st2_t3_idle", V_IDLE);

    // mem_ack high in IDLE and EXEC must be ignored
    bus.mem_ack = 1'b1; present(4'd2);
    tick(); drop(); chk("ign_exec", V_ZERO);
    tick(); bus.mem_ack = 1'b0; chk("ign_mem1", ev(0, 0, 0, 1, 0, 0, 0, 0));
    tick(); chk("ign_mem2", ev(0, 0, 0, 1, 0, 0, 0, 0)); bus.mem_ack = 1'b1;
    tick(); bus.mem_ack = 1'b0; chk("ign_wb", ev(0, 1, 0, 0, 0, 2, 0, 0));
    tick(); chk("ign_idle", V_IDLE);

    // Asynchronous reset in the middle of a LOAD's MEM phase
    present(4'd2);
    tick(); drop();
    tick(); chk("ar_mem1", ev(0, 0, 0, 1, 0, 0, 0, 0));
    tick(); chk("ar_mem2", ev(0, 0, 0, 1, 0, 0, 0, 0));
    #3 rst_n = 1'b0;
    #1 chk("ar_async_drop", V_ZERO);
    tick(); chk("ar_held", V_ZERO);
    rst_n = 1'b1;
    #1 chk("ar_release", V_IDLE);
    present(4'd0);
    tick(); drop(); chk("ar_add_exec", V_ZERO);
    tick(); chk("ar_add_wb", ev(0, 1, 0, 0, 0, 0, 0, 0));
    tick(); chk("ar_add_idle", V_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
